word_serializer: RTL and testbench

Upstream feeder for the bit-serial two's-complement stage. Accepts a parallel W-bit word over a valid/ready handshake, issues a one-cycle frame-clear pulse that resets the downstream complement stage, then shifts the word out LSB first, one bit per clock. Its `ser_bit` drives the complement stage's data input and `frame_clr` drives that stage's reset input.

---
 rtl/word_serializer_if.sv | 33 +++
 rtl/word_serializer.sv | 80 ++++++++
 tb/tb_word_serializer.sv | 110 +++++++++++
 3 files changed

// File: rtl/word_serializer_if.sv
// Handshake and serial-out bundle for word_serializer.
// The slave side is the serializer; the master side feeds words in.
interface word_serializer_if #(
  parameter int W = 8
);
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         frame_clr;
  logic         ser_bit;
  logic         ser_valid;
  logic         ser_last;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  frame_clr,
    input  ser_bit,
    input  ser_valid,
    input  ser_last
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output frame_clr,
    output ser_bit,
    output ser_valid,
    output ser_last
  );
endinterface

// File: rtl/word_serializer.sv
// Parallel-in, LSB-first serial-out feeder with a frame-clear pulse
// ahead of each word for the downstream two's-complement stage.
module word_serializer #(
  parameter int W = 8
) (
  input  logic                t_clk,
  input  logic                r,
  word_serializer_if.slave    bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SHIFT
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;
  logic          accept;

  assign at_last = (state_q == SHIFT) && (cnt_q == LAST);

  // Only load_ready looks at r combinationally.
  assign bus.load_ready = ~r & ((state_q == IDLE) | at_last);
  assign accept = bus.load_valid & bus.load_ready;

  always_ff @(posedge t_clk) begin
    if (r) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CLR;
          sh_d    = bus.load_data;
          cnt_d   = '0;
        end
      end
      CLR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end else if (accept) begin
          state_d = CLR;
          sh_d    = bus.load_data;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.frame_clr = (state_q == CLR);
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_bit   = (state_q == SHIFT) & sh_q[0];
  assign bus.ser_last  = at_last;
endmodule

// File: tb/tb_word_serializer.sv
// Randomized bench for word_serializer against a frame-queue model,
// including a behavioural downstream two's-complement stage.
module tb_word_serializer;
  localparam int W = 8;

  logic t_clk = 1'b0;
  logic r;

  always #5 t_clk = ~t_clk;

  word_serializer_if #(.W(W)) bus ();

  word_serializer #(.W(W)) dut (
    .t_clk (t_clk),
    .r     (r),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_t[$];
  // Each entry is one expected output cycle:
  // {frame_clr, ser_valid, ser_bit, ser_last, negated_bit}
  logic [4:0] exp_q[$];
  logic seen;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    logic [W-1:0] neg;
    neg = -d;
    exp_q.push_back(5'b10000);
    for (int k = 0; k < W; k++)
      exp_q.push_back({1'b0, 1'b1, d[k], (k == W - 1), neg[k]});
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d,
                       input logic rr);
    logic [4:0] e;
    logic rdy;
    r = rr;
    bus.load_valid = v;
    bus.load_data = d;
    @(negedge t_clk);
    e = (exp_q.size() != 0) ? exp_q[0] : 5'b0;
    rdy = !rr && (exp_q.size() <= 1);
    chk("load_ready", 32'(bus.load_ready), 32'(rdy));
    chk("outputs", 32'({bus.frame_clr, bus.ser_valid,
                        bus.ser_bit, bus.ser_last}), 32'(e[4:1]));
    if (bus.ser_valid)
      chk("chain", 32'(bus.ser_bit ^ seen), 32'(e[0]));
    if (bus.frame_clr) clr_t.push_back(cyc);
    if (bus.frame_clr) seen = 1'b0;
    else if (bus.ser_valid && bus.ser_bit) seen = 1'b1;
    @(posedge t_clk);
    cyc++;
    if (rr) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (v && rdy) push_frame(d);
    end
    #1;
  endtask

  initial begin
    seen = 1'b0;
    r = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'h55;
    @(posedge t_clk);
    #1;

    cycle(1'b1, 8'h55, 1'b1);
    cycle(1'b1, 8'hAA, 1'b1);

    cycle(1'b1, 8'h0C, 1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b0, W'($urandom), 1'b0);

    clr_t.delete();
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, W'($urandom), 1'b0);
    chk("clr_count", 32'(clr_t.size()), 32'd2);
    if (clr_t.size() == 2)
      chk("period", 32'(clr_t[1] - clr_t[0]), 32'd9);

    cycle(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, W'($urandom), 1'b0);
    cycle(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, W'($urandom), 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b0, W'($urandom), 1'b0);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 2) != 0, W'($urandom),
            $urandom_range(0, 59) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
